// File: rtl/cordic_sched_pkg.sv
// Shared types, constants and helpers for the round-robin cordic scheduler.
package cordic_sched_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  // Watchdog width; TIMEOUT must fit in it.
  localparam int unsigned WDOG_W     = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// Requester-side and core-side bus of the cordic scheduler.
interface cordic_rr_scheduler_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_start;
  logic [NUM_REQ*DATA_W-1:0] req_dataa;
  logic [NUM_REQ-1:0]        req_done;
  logic [DATA_W-1:0]         req_result;
  logic                      req_timeout;
  logic                      core_start;
  logic [DATA_W-1:0]         core_dataa;
  logic                      core_done;
  logic [DATA_W-1:0]         core_result;

  modport slave (
    input  req_start, req_dataa, core_done, core_result,
    output req_done, req_result, req_timeout, core_start, core_dataa
  );

  modport master (
    output req_start, req_dataa, core_done, core_result,
    input  req_done, req_result, req_timeout, core_start, core_dataa
  );
endinterface

// File: rtl/cordic_rr_scheduler_rr_picker.sv
// Circular priority pick: first pending requester after last_i wins.
module rr_picker
  import cordic_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   grant_c_o,
  output logic               any_c_o
);

  // Scan farthest-first so the nearest pending requester overwrites last.
  always_comb begin
    grant_c_o = '0;
    any_c_o   = 1'b0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      int unsigned idx;
      idx = (32'(last_i) + k) % NUM_REQ;
      if (pending_i[IDX_W'(idx)]) begin
        grant_c_o = IDX_W'(idx);
        any_c_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one cordic core among NUM_REQ requesters: latch, round-robin grant,
// watchdog-guarded operation and one-cycle completion pulse back.
module cordic_rr_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                  clock,
  input logic                  reset_n,
  input logic                  clk_en,
  cordic_rr_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(NUM_REQ);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d, clr_c;
  logic [DATA_W-1:0]    opnd_q [NUM_REQ];
  logic [DATA_W-1:0]    opnd_d [NUM_REQ];
  logic [IDX_W-1:0]     last_q, last_d, grant_c;
  logic                 any_c;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0]    result_q, result_d;
  logic [DATA_W-1:0]    dataa_q, dataa_d;
  logic                 timeout_q, timeout_d;
  logic                 start_q, start_d;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .pending_i (pending_q),
    .last_i    (last_q),
    .grant_c_o (grant_c),
    .any_c_o   (any_c)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      opnd_q    <= '{default: '0};
      last_q    <= IDX_W'(NUM_REQ - 1);
      wdog_q    <= '0;
      done_q    <= '0;
      result_q  <= '0;
      dataa_q   <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      pending_q <= pending_d;
      opnd_q    <= opnd_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      done_q    <= done_d;
      result_q  <= result_d;
      dataa_q   <= dataa_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
    end
  end

  // last_q doubles as the current grant while an op is in flight.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    opnd_d    = opnd_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    done_d    = done_q;
    result_d  = result_q;
    dataa_d   = dataa_q;
    timeout_d = timeout_q;
    start_d   = start_q;
    clr_c     = '0;

    case (state_q)
      ST_IDLE: begin
        if (any_c) begin
          dataa_d = opnd_q[grant_c];
          start_d = 1'b1;
          last_d  = grant_c;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        start_d = 1'b0;
        wdog_d  = wdog_q + WDOG_W'(1);
        if (bus.core_done) begin
          result_d      = bus.core_result;
          done_d        = NUM_REQ'(1) << last_q;
          timeout_d     = 1'b0;
          clr_c[last_q] = 1'b1;
          state_d       = ST_RESP;
        end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          result_d      = '0;
          done_d        = NUM_REQ'(1) << last_q;
          timeout_d     = 1'b1;
          clr_c[last_q] = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        done_d    = '0;
        timeout_d = 1'b0;
        wdog_d    = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new start on the clearing edge re-arms the slot with the new operand.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (bus.req_start[i] && (!pending_q[i] || clr_c[i])) begin
        pending_d[i] = 1'b1;
        opnd_d[i]    = bus.req_dataa[i*DATA_W +: DATA_W];
      end else if (clr_c[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  assign bus.req_done    = done_q;
  assign bus.req_result  = result_q;
  assign bus.req_timeout = timeout_q;
  assign bus.core_start  = start_q;
  assign bus.core_dataa  = dataa_q;

endmodule
